cdb_arbiter: RTL and testbench

- Shares the two ROB result write ports (slot 1: write/val_idx/value; slot 2: write2/val_idx2/value2) among NREQ completing functional units (ALUs, multiplier, load units).
- Each cycle it grants up to two requesters in round-robin order and acknowledges them in the same cycle.
- Granted results are registered onto the two CDB slots with one cycle of latency.
- Sits between the execution units and the ROB/reservation-station broadcast.

---
 rtl/cdb_arbiter.sv | 154 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Round-robin arbiter that shares the two ROB result write ports
//            (common data bus slots 1 and 2) among NREQ completing
//            functional units. Up to two requesters are acknowledged per
//            cycle; their payloads appear on the CDB one cycle later.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            flush, stall          - discard in-flight / back-pressure
//            req_valid/tag/value   - per-requester result offers (packed)
//            req_ack               - combinational per-requester accept
//            write/val_idx/value   - CDB slot 1 (registered)
//            write2/val_idx2/value2- CDB slot 2 (registered)
//            rr_ptr                - round-robin start index
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NREQ   = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int PTR_W  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    stall,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*TAG_W-1:0]   req_tag,
    input  logic [NREQ*DATA_W-1:0]  req_value,
    output logic [NREQ-1:0]         req_ack,
    output logic                    write,
    output logic [TAG_W-1:0]        val_idx,
    output logic [DATA_W-1:0]       value,
    output logic                    write2,
    output logic [TAG_W-1:0]        val_idx2,
    output logic [DATA_W-1:0]       value2,
    output logic [PTR_W-1:0]        rr_ptr
);

    localparam logic [PTR_W:0]   c_NREQ = (PTR_W+1)'(NREQ);
    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(NREQ - 1);

    // Unpacked views of the per-requester payload buses.
    logic [TAG_W-1:0]  w_tag [NREQ];
    logic [DATA_W-1:0] w_val [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_tag[gi] = req_tag[gi*TAG_W +: TAG_W];
        assign w_val[gi] = req_value[gi*DATA_W +: DATA_W];
    end

    logic              r_write, r_write2;
    logic [TAG_W-1:0]  r_idx1, r_idx2;
    logic [DATA_W-1:0] r_val1, r_val2;
    logic [PTR_W-1:0]  r_ptr;

    logic              w_g1_found, w_g2_found;
    logic [PTR_W-1:0]  w_g1, w_g2;
    logic [PTR_W:0]    w_sum;
    logic [PTR_W-1:0]  w_idx;
    logic [NREQ-1:0]   w_ack;
    logic [PTR_W-1:0]  w_ptr_next;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] x);
        return (x == c_LAST) ? '0 : x + 1'b1;
    endfunction

    // Scan from r_ptr upward with wrap; first two valid requesters win.
    always_comb begin
        w_g1_found = 1'b0;
        w_g2_found = 1'b0;
        w_g1       = '0;
        w_g2       = '0;
        w_sum      = '0;
        w_idx      = '0;
        w_ack      = '0;
        if (!rst && !flush && !stall) begin
            for (int k = 0; k < NREQ; k++) begin
                w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
                if (w_sum >= c_NREQ) begin
                    w_sum = w_sum - c_NREQ;
                end
                w_idx = w_sum[PTR_W-1:0];
                if (req_valid[w_idx]) begin
                    if (!w_g1_found) begin
                        w_g1_found = 1'b1;
                        w_g1       = w_idx;
                    end else if (!w_g2_found) begin
                        w_g2_found = 1'b1;
                        w_g2       = w_idx;
                    end
                end
            end
            if (w_g1_found) begin
                w_ack[w_g1] = 1'b1;
            end
            if (w_g2_found) begin
                w_ack[w_g2] = 1'b1;
            end
        end
    end

    // The pointer moves just past the last winner so that the losers of
    // this cycle are scanned first next cycle.
    always_comb begin
        w_ptr_next = r_ptr;
        if (w_g2_found) begin
            w_ptr_next = wrap_inc(w_g2);
        end else if (w_g1_found) begin
            w_ptr_next = wrap_inc(w_g1);
        end
    end

    // Grants are already suppressed under stall, so the normal branch
    // naturally clears the valids and holds the pointer in that case.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write  <= 1'b0;
            r_write2 <= 1'b0;
            r_idx1   <= '0;
            r_idx2   <= '0;
            r_val1   <= '0;
            r_val2   <= '0;
            r_ptr    <= '0;
        end else if (flush) begin
            r_write  <= 1'b0;
            r_write2 <= 1'b0;
            r_ptr    <= '0;
        end else begin
            r_write  <= w_g1_found;
            r_write2 <= w_g2_found;
            if (w_g1_found) begin
                r_idx1 <= w_tag[w_g1];
                r_val1 <= w_val[w_g1];
            end
            if (w_g2_found) begin
                r_idx2 <= w_tag[w_g2];
                r_val2 <= w_val[w_g2];
            end
            r_ptr <= w_ptr_next;
        end
    end

    assign req_ack  = w_ack;
    assign write    = r_write;
    assign write2   = r_write2;
    assign val_idx  = r_idx1;
    assign val_idx2 = r_idx2;
    assign value    = r_val1;
    assign value2   = r_val2;
    assign rr_ptr   = r_ptr;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Purpose  : Self-checking bench for cdb_arbiter (NREQ=4): directed vector
//            table for the listed scenarios, then randomized traffic against
//            a distance-based round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst, flush, stall;
    logic [N-1:0]    req_valid;
    logic [N*TW-1:0] req_tag;
    logic [N*DW-1:0] req_value;
    logic [N-1:0]    req_ack;
    logic            write, write2;
    logic [TW-1:0]   val_idx, val_idx2;
    logic [DW-1:0]   value, value2;
    logic [1:0]      rr_ptr;

    int errors = 0;
    int checks = 0;

    cdb_arbiter #(.NREQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .req_valid(req_valid), .req_tag(req_tag), .req_value(req_value),
        .req_ack(req_ack),
        .write(write), .val_idx(val_idx), .value(value),
        .write2(write2), .val_idx2(val_idx2), .value2(value2),
        .rr_ptr(rr_ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the two valid requesters closest (cyclically, forward) to ptr.
    function automatic void pick(input logic [N-1:0] v, input int p,
                                 output int g1, output int g2);
        int d1, d2, d;
        g1 = -1; g2 = -1; d1 = N; d2 = N;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                d = (i - p + N) % N;
                if (d < d1) begin
                    g2 = g1; d2 = d1; g1 = i; d1 = d;
                end else if (d < d2) begin
                    g2 = i; d2 = d;
                end
            end
        end
    endfunction

    typedef struct {
        logic          rst, flush, stall;
        logic [N-1:0]  valid;
        logic [TW-1:0] t3;
        logic [DW-1:0] v3;
        logic [N-1:0]  ack;
        int            e1, e2, ptr;
    } vec_t;

    vec_t vecs [18];

    localparam logic [DW-1:0] VA3 = 32'hA000_0003;

    initial begin
        logic [TW-1:0] tg [N];
        logic [DW-1:0] vl [N];
        logic          pend [N];
        logic [TW-1:0] ptag [N];
        logic [DW-1:0] pval [N];
        int            m_ptr, g1, g2;
        logic          m_w, m_w2;
        logic [TW-1:0] m_i1, m_i2;
        logic [DW-1:0] m_v1, m_v2;
        logic [N-1:0]  eack;

        vecs[0]  = '{1,0,0,4'hF,5'd12,VA3,4'h0,-1,-1,0};
        vecs[1]  = '{1,0,0,4'hF,5'd12,VA3,4'h0,-1,-1,0};
        vecs[2]  = '{0,0,0,4'hF,5'd12,VA3,4'h3, 0, 1,2};
        vecs[3]  = '{0,0,0,4'hF,5'd12,VA3,4'hC, 2, 3,0};
        vecs[4]  = '{0,0,0,4'hF,5'd12,VA3,4'h3, 0, 1,2};
        vecs[5]  = '{0,0,0,4'hF,5'd12,VA3,4'hC, 2, 3,0};
        vecs[6]  = '{0,0,0,4'h1,5'd12,VA3,4'h1, 0,-1,1};
        vecs[7]  = '{0,0,0,4'h8,5'd5,32'hDEADBEEF,4'h8, 3,-1,0};
        vecs[8]  = '{0,0,0,4'h3,5'd12,VA3,4'h3, 0, 1,2};
        vecs[9]  = '{0,0,1,4'hF,5'd12,VA3,4'h0,-1,-1,2};
        vecs[10] = '{0,0,1,4'hF,5'd12,VA3,4'h0,-1,-1,2};
        vecs[11] = '{0,0,1,4'hF,5'd12,VA3,4'h0,-1,-1,2};
        vecs[12] = '{0,0,0,4'hF,5'd12,VA3,4'hC, 2, 3,0};
        vecs[13] = '{0,0,0,4'h4,5'd12,VA3,4'h4, 2,-1,3};
        vecs[14] = '{0,1,1,4'hF,5'd12,VA3,4'h0,-1,-1,0};
        vecs[15] = '{0,0,0,4'hF,5'd12,VA3,4'h3, 0, 1,2};
        vecs[16] = '{0,1,0,4'h2,5'd12,VA3,4'h0,-1,-1,0};
        vecs[17] = '{0,0,0,4'h2,5'd12,VA3,4'h2, 1,-1,2};

        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        req_valid = '0; req_tag = '0; req_value = '0;

        // ---------------- directed vector table ----------------
        for (int r = 0; r < 18; r++) begin
            @(negedge clk);
            tg[0] = 5'd3; tg[1] = 5'd7; tg[2] = 5'd9; tg[3] = vecs[r].t3;
            vl[0] = 32'hA000_0000; vl[1] = 32'hA000_0001;
            vl[2] = 32'hA000_0002; vl[3] = vecs[r].v3;
            rst = vecs[r].rst; flush = vecs[r].flush; stall = vecs[r].stall;
            req_valid = vecs[r].valid;
            for (int i = 0; i < N; i++) begin
                req_tag[i*TW +: TW]   = tg[i];
                req_value[i*DW +: DW] = vl[i];
            end
            #1 chk($sformatf("vec%0d ack", r), 64'(req_ack), 64'(vecs[r].ack));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d write", r),  64'(write),  64'(vecs[r].e1 >= 0));
            chk($sformatf("vec%0d write2", r), 64'(write2), 64'(vecs[r].e2 >= 0));
            chk($sformatf("vec%0d rr_ptr", r), 64'(rr_ptr), 64'(vecs[r].ptr));
            if (vecs[r].e1 >= 0) begin
                chk($sformatf("vec%0d val_idx", r), 64'(val_idx), 64'(tg[vecs[r].e1]));
                chk($sformatf("vec%0d value", r),   64'(value),   64'(vl[vecs[r].e1]));
            end
            if (vecs[r].e2 >= 0) begin
                chk($sformatf("vec%0d val_idx2", r), 64'(val_idx2), 64'(tg[vecs[r].e2]));
                chk($sformatf("vec%0d value2", r),   64'(value2),   64'(vl[vecs[r].e2]));
            end
            if (vecs[r].rst) begin
                chk($sformatf("vec%0d rst idx", r), 64'({val_idx, val_idx2}), 64'(0));
                chk($sformatf("vec%0d rst val", r), 64'({value, value2}), 64'(0));
            end
        end

        // ---------------- randomized traffic vs. model ----------------
        m_ptr = 0; m_w = 0; m_w2 = 0; m_i1 = '0; m_i2 = '0; m_v1 = '0; m_v2 = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; ptag[i] = '0; pval[i] = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst   = (c == 0) || ($urandom_range(63) == 0);
            flush = ($urandom_range(31) == 0);
            stall = ($urandom_range(7) == 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(1) == 1) begin
                    pend[i] = 1'b1;
                    ptag[i] = TW'($urandom);
                    pval[i] = $urandom;
                end
                req_valid[i]          = pend[i];
                req_tag[i*TW +: TW]   = ptag[i];
                req_value[i*DW +: DW] = pval[i];
            end

            g1 = -1; g2 = -1;
            if (!rst && !flush && !stall) begin
                pick(req_valid, m_ptr, g1, g2);
            end
            eack = '0;
            if (g1 >= 0) eack[g1] = 1'b1;
            if (g2 >= 0) eack[g2] = 1'b1;
            #1 chk("rand ack", 64'(req_ack), 64'(eack));

            @(posedge clk);
            if (rst) begin
                m_w = 0; m_w2 = 0; m_i1 = '0; m_i2 = '0; m_v1 = '0; m_v2 = '0; m_ptr = 0;
            end else if (flush) begin
                m_w = 0; m_w2 = 0; m_ptr = 0;
            end else begin
                m_w  = (g1 >= 0);
                m_w2 = (g2 >= 0);
                if (g1 >= 0) begin m_i1 = ptag[g1]; m_v1 = pval[g1]; end
                if (g2 >= 0) begin m_i2 = ptag[g2]; m_v2 = pval[g2]; end
                if (g2 >= 0)      m_ptr = (g2 + 1) % N;
                else if (g1 >= 0) m_ptr = (g1 + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (eack[i] || rst || flush) pend[i] = 1'b0;
            end
            #1;
            chk("rand write",  64'(write),  64'(m_w));
            chk("rand write2", 64'(write2), 64'(m_w2));
            chk("rand rr_ptr", 64'(rr_ptr), 64'(m_ptr));
            if (m_w) begin
                chk("rand val_idx", 64'(val_idx), 64'(m_i1));
                chk("rand value",   64'(value),   64'(m_v1));
            end
            if (m_w2) begin
                chk("rand val_idx2", 64'(val_idx2), 64'(m_i2));
                chk("rand value2",   64'(value2),   64'(m_v2));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
